// File: rtl/relobi_tmr_a_reg.sv
// relobi_tmr_a_reg: request-side (A channel) TMR voter for relOBI.
// Majority-votes the three replicated requests and A channels, registers the
// voted request in a one-entry output buffer and fans a single grant back to
// all replicas. Per-replica consecutive-mismatch counters and sticky fault
// flags point the safety controller at a diverging core.
//
// The A channel (address, write enable, byte enables, write data with ECC, id,
// optional fields and their ECC) is voted as an opaque bit vector, so optional
// fields are covered automatically and ECC bits pass through exactly as voted.
//
// Ports:
//   clk_i, rst_i    clock, synchronous active-high reset
//   three_req_i     request from replicas 0..2
//   three_a_i       A channel from replicas 0..2
//   three_gnt_o     grant to replicas (all bits identical, combinational)
//   req_o, a_o      registered voted request / A channel
//   gnt_i           downstream grant
//   clear_i         clears counters and fault flags
//   err_cnt_o       per-replica consecutive-mismatch count (saturating)
//   fault_o         sticky per-replica fault flag
//   multi_err_o     one-cycle pulse after an event with >=2 mismatching replicas
module relobi_tmr_a_reg #(
  parameter type         obi_a_chan_t   = logic,
  parameter int unsigned FaultThreshold = 4,
  parameter int unsigned CntWidth       = 8
) (
  input  logic                         clk_i,
  input  logic                         rst_i,
  input  logic        [2:0]            three_req_i,
  input  obi_a_chan_t [2:0]            three_a_i,
  output logic        [2:0]            three_gnt_o,
  output logic                         req_o,
  output obi_a_chan_t                  a_o,
  input  logic                         gnt_i,
  input  logic                         clear_i,
  output logic        [2:0][CntWidth-1:0] err_cnt_o,
  output logic        [2:0]            fault_o,
  output logic                         multi_err_o
);

  localparam int unsigned AW = $bits(obi_a_chan_t);

  typedef enum logic {StEmpty, StFull} state_e;

  state_e                   state_q, state_d;
  logic [2:0][AW-1:0]       rep_a;
  logic [AW-1:0]            v_a;
  logic [AW-1:0]            a_q, a_d;
  logic                     v_req, acc;
  logic [2:0]               mism;
  logic [2:0][CntWidth-1:0] cnt_q, cnt_d;
  logic [2:0]               fault_q, fault_d;
  logic                     multi_q, multi_d;

  // Voting
  assign rep_a = three_a_i;
  assign v_a   = (rep_a[0] & rep_a[1]) | (rep_a[0] & rep_a[2]) | (rep_a[1] & rep_a[2]);
  assign v_req = (three_req_i[0] & three_req_i[1]) | (three_req_i[0] & three_req_i[2]) |
                 (three_req_i[1] & three_req_i[2]);

  // Reset masks the grant so no replica sees a handshake while the buffer clears.
  assign acc         = v_req && ((state_q == StEmpty) || gnt_i) && !rst_i;
  assign three_gnt_o = {3{acc}};

  // Output buffer
  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    if (acc) begin
      state_d = StFull;
      a_d     = v_a;
    end else if ((state_q == StFull) && gnt_i) begin
      state_d = StEmpty;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= StEmpty;
      a_q     <= '0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
    end
  end

  assign req_o = (state_q == StFull);
  assign a_o   = a_q;

  // Compare events, counters and fault flags
  always_comb begin
    mism    = '0;
    cnt_d   = cnt_q;
    fault_d = fault_q;
    for (int k = 0; k < 3; k++) begin
      if (acc) begin
        mism[k] = !three_req_i[k] || (rep_a[k] != v_a);
      end else begin
        // Stall cycles (v_req && !acc) are not compare events.
        mism[k] = !v_req && three_req_i[k];
      end
    end
    multi_d = (mism[0] & mism[1]) | (mism[0] & mism[2]) | (mism[1] & mism[2]);
    for (int k = 0; k < 3; k++) begin
      // Looks at the already-registered count, hence the extra cycle of lag.
      fault_d[k] = fault_q[k] | (cnt_q[k] >= CntWidth'(FaultThreshold));
      if (mism[k]) begin
        if (cnt_q[k] != {CntWidth{1'b1}}) begin
          cnt_d[k] = cnt_q[k] + 1'b1;
        end
      end else if (acc) begin
        cnt_d[k] = '0;
      end
    end
    if (clear_i) begin
      cnt_d   = '0;
      fault_d = '0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q   <= '0;
      fault_q <= '0;
      multi_q <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      fault_q <= fault_d;
      multi_q <= multi_d;
    end
  end

  assign err_cnt_o   = cnt_q;
  assign fault_o     = fault_q;
  assign multi_err_o = multi_q;

endmodule
